// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode control and operands for the execute stage.
// Supports stall (hold), bubble insertion (flush) and a saturating bubble counter.
module id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic [31:0]      RS1data_i,
  input  logic [31:0]      RS2data_i,
  input  logic [31:0]      Imm_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic [31:0]      RS1data_o,
  output logic [31:0]      RS2data_o,
  output logic [31:0]      Imm_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic             rd_nz_s;
  logic [CNT_W-1:0] cnt_max_s;
  logic [CNT_W-1:0] cnt_next_s;

  assign cnt_max_s = {CNT_W{1'b1}};

  // Write-to-x0 filter and saturating next value of the bubble counter.
  always_comb begin
    rd_nz_s    = 1'b0;
    cnt_next_s = bubble_cnt_o;
    rd_nz_s    = (RDaddr_i != 5'd0);
    if (bubble_cnt_o == cnt_max_s) begin
      cnt_next_s = bubble_cnt_o;
    end else begin
      cnt_next_s = bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline register: flush beats hold, hold freezes everything, otherwise load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      MemRead_o    <= 1'b0;
      MemWrite_o   <= 1'b0;
      ALUOp_o      <= 2'b00;
      ALUSrc_o     <= 1'b0;
      RS1data_o    <= 32'h0000_0000;
      RS2data_o    <= 32'h0000_0000;
      Imm_o        <= 32'h0000_0000;
      funct_o      <= 10'd0;
      RS1addr_o    <= 5'd0;
      RS2addr_o    <= 5'd0;
      RDaddr_o     <= 5'd0;
      valid_o      <= 1'b0;
      bubble_cnt_o <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      MemRead_o    <= 1'b0;
      MemWrite_o   <= 1'b0;
      ALUOp_o      <= 2'b00;
      ALUSrc_o     <= 1'b0;
      RS1data_o    <= 32'h0000_0000;
      RS2data_o    <= 32'h0000_0000;
      Imm_o        <= 32'h0000_0000;
      funct_o      <= 10'd0;
      RS1addr_o    <= 5'd0;
      RS2addr_o    <= 5'd0;
      RDaddr_o     <= 5'd0;
      valid_o      <= 1'b0;
      bubble_cnt_o <= cnt_next_s;
    end else if (!hold_i) begin
      RegWrite_o   <= RegWrite_i & rd_nz_s;
      MemtoReg_o   <= MemtoReg_i;
      MemRead_o    <= MemRead_i;
      MemWrite_o   <= MemWrite_i;
      ALUOp_o      <= ALUOp_i;
      ALUSrc_o     <= ALUSrc_i;
      RS1data_o    <= RS1data_i;
      RS2data_o    <= RS2data_i;
      Imm_o        <= Imm_i;
      funct_o      <= funct_i;
      RS1addr_o    <= RS1addr_i;
      RS2addr_o    <= RS2addr_i;
      RDaddr_o     <= RDaddr_i;
      valid_o      <= 1'b1;
      bubble_cnt_o <= bubble_cnt_o;
    end else begin
      valid_o      <= valid_o;
      bubble_cnt_o <= bubble_cnt_o;
    end
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: CNT_W, default 16, width of bubble counter.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 hold_i  in  1  downstream stall; freeze all registers.
REQ-005 flush_i  in  1  insert bubble (branch taken / load-use hazard).
REQ-006 RegWrite_i / RegWrite_o  in/out  1  register-file write enable from decode control.
REQ-007 MemtoReg_i / MemtoReg_o  in/out  1  writeback source select.
REQ-008 MemRead_i / MemRead_o  in/out  1  data-memory read.
REQ-009 MemWrite_i / MemWrite_o  in/out  1  data-memory write.
REQ-010 ALUOp_i / ALUOp_o  in/out  2  ALU op class (2'b10 R-type, 2'b00 add).
REQ-011 ALUSrc_i / ALUSrc_o  in/out  1  ALU operand-B select (1 = immediate).
REQ-012 RS1data_i / RS1data_o  in/out  32  register-file read data 1.
REQ-013 RS2data_i / RS2data_o  in/out  32  register-file read data 2.
REQ-014 Imm_i / Imm_o  in/out  32  sign-extended immediate.
REQ-015 funct_i / funct_o  in/out  10  {funct7, funct3}.
REQ-016 RS1addr_i / RS1addr_o, RS2addr_i / RS2addr_o, RDaddr_i / RDaddr_o  in/out  5 each  register indices (forwarding/hazard use).
REQ-017 valid_o  out  1  stage holds a real instruction.
REQ-018 bubble_cnt_o  out  CNT_W  count of bubbles inserted.

Function
REQ-019 All outputs SHALL be registered; latency input-to-output exactly 1 cycle.
REQ-020 Load (hold_i=0, flush_i=0): all _o fields SHALL capture their _i values; valid_o SHALL become 1.
REQ-021 RegWrite_o SHALL capture RegWrite_i AND (RDaddr_i != 0); writes to x0 never propagate.
REQ-022 Hold (hold_i=1, flush_i=0): every output, valid_o and bubble_cnt_o SHALL keep its value.
REQ-023 Flush (flush_i=1): RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o SHALL become 0, ALUOp_o 2'b00, valid_o 0; data/address fields SHALL become 0.
REQ-024 flush_i=1 with hold_i=1: flush SHALL win.
REQ-025 bubble_cnt_o SHALL increment by 1 on each flush edge; saturates at all-ones (no wrap).
REQ-026 Two-state behaviour only: EMPTY (valid_o=0) / FULL (valid_o=1); EMPTY->FULL on load, FULL->EMPTY on flush, hold keeps state.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 rst_i low SHALL immediately (no clock) force all outputs, valid_o and bubble_cnt_o to 0.
REQ-029 While rst_i low, hold_i/flush_i/data inputs SHALL be ignored.
REQ-030 First rising edge after rst_i rises SHALL behave per REQ-020..025.
REQ-031 Reset asserted mid-hold SHALL clear state; held contents are lost.

Verification
REQ-032 Load: RegWrite_i=1, ALUOp_i=2'b10, ALUSrc_i=0, RS1data_i=32'h0000_0005, RDaddr_i=5'd3 -> next edge same values out, valid_o=1.
REQ-033 x0 filter: RegWrite_i=1, RDaddr_i=0 -> RegWrite_o=0, RDaddr_o=0, valid_o=1.
REQ-034 Hold: load Imm_i=32'hFFFF_FFF0, then hold_i=1 for 3 cycles with Imm_i=1 -> Imm_o stays 32'hFFFF_FFF0.
REQ-035 Flush+hold: hold_i=1, flush_i=1 with MemWrite_i=1 -> MemWrite_o=0, valid_o=0, bubble_cnt_o=1.
REQ-036 Saturation: CNT_W=2, 5 consecutive flushes -> bubble_cnt_o = 1,2,3,3,3.
REQ-037 Async reset: drop rst_i mid-cycle while FULL -> all outputs 0 before next clock edge.
